// File: rtl/reg_file_sb_pkg.sv
// reg_file_sb_pkg: shared defaults and sign-extension helper for the register file
package reg_file_sb_pkg;
  localparam int DEF_DATA_W      = 8;
  localparam int DEF_NUM_REGS    = 8;
  localparam int DEF_IMM_W       = 6;
  localparam int DEF_SHORT_IMM_W = 3;
  localparam int DEF_ADDR_W      = $clog2(DEF_NUM_REGS);
  function automatic logic [63:0] sext(input logic [63:0] v, input int w);
    logic [63:0] r;
    for (int i = 0; i < 64; i++) r[i] = (i < w) ? v[i] : v[w-1];
    return r;
  endfunction
endpackage

// File: rtl/reg_file_sb_if.sv
// reg_file_sb_if: decode-stage bus between the core and the register file
interface reg_file_sb_if
  import reg_file_sb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int IMM_W  = DEF_IMM_W
);
  logic [ADDR_W-1:0] Rd1_Reg;
  logic              Rd1_En;
  logic [DATA_W-1:0] Rd1_Data;
  logic [ADDR_W-1:0] Rd2_Reg;
  logic              Rd2_En;
  logic [DATA_W-1:0] Rd2_Data;
  logic [ADDR_W-1:0] Wr_Reg;
  logic [DATA_W-1:0] Wr_Data;
  logic              RegWrite;
  logic              Issue_Valid;
  logic [ADDR_W-1:0] Issue_Dest;
  logic              Issue_Ready;
  logic              Issue_Err;
  logic              Stall;
  logic [IMM_W-1:0]  Immediate_Raw;
  logic              ImmSel;
  logic [DATA_W-1:0] Imm_Data;
  modport master (
    output Rd1_Reg, Rd1_En, Rd2_Reg, Rd2_En, Wr_Reg, Wr_Data, RegWrite,
           Issue_Valid, Issue_Dest, Immediate_Raw, ImmSel,
    input  Rd1_Data, Rd2_Data, Issue_Ready, Issue_Err, Stall, Imm_Data
  );
  modport slave (
    input  Rd1_Reg, Rd1_En, Rd2_Reg, Rd2_En, Wr_Reg, Wr_Data, RegWrite,
           Issue_Valid, Issue_Dest, Immediate_Raw, ImmSel,
    output Rd1_Data, Rd2_Data, Issue_Ready, Issue_Err, Stall, Imm_Data
  );
endinterface

// File: rtl/reg_file_sb_scoreboard.sv
// reg_scoreboard: pending-write busy bits, issue legality and read-stall generation
module reg_scoreboard #(
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int ZERO_REG = 0
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [ADDR_W-1:0] i_rd1_reg,
  input  logic              i_rd1_en,
  input  logic [ADDR_W-1:0] i_rd2_reg,
  input  logic              i_rd2_en,
  input  logic [ADDR_W-1:0] i_wr_reg,
  input  logic              i_wr_en,
  input  logic              i_issue_valid,
  input  logic [ADDR_W-1:0] i_issue_dest,
  output logic              o_issue_ready,
  output logic              o_issue_err,
  output logic              o_stall
);
  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_set;
  logic [NUM_REGS-1:0] w_clr;
  logic                w_dest_zero;
  logic                w_pend1;
  logic                w_pend2;
  logic                r_err;
  // issue legality, set/clear masks and per-port hazard detection
  always_comb begin
    w_dest_zero = (ZERO_REG != 0) && (i_issue_dest == '0);
    o_issue_ready = ~r_busy[i_issue_dest] | (i_wr_en && i_wr_reg == i_issue_dest) | w_dest_zero;
    w_clr = '0;
    w_clr[i_wr_reg] = i_wr_en;
    w_set = '0;
    w_set[i_issue_dest] = i_issue_valid & o_issue_ready & ~w_dest_zero;
    w_pend1 = r_busy[i_rd1_reg] & ~(i_wr_en && i_wr_reg == i_rd1_reg);
    w_pend2 = r_busy[i_rd2_reg] & ~(i_wr_en && i_wr_reg == i_rd2_reg);
    o_stall = (i_rd1_en & w_pend1) | (i_rd2_en & w_pend2);
  end
  // busy vector update (a new producer outranks a completing write) and error pulse
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_busy <= '0;
      r_err  <= 1'b0;
    end else begin
      r_busy <= (r_busy & ~w_clr) | w_set;
      r_err  <= i_issue_valid & ~o_issue_ready;
    end
  end
  assign o_issue_err = r_err;
endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: two-read/one-write register file with bypass, scoreboard and immediate extender
module reg_file_sb
  import reg_file_sb_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int NUM_REGS    = DEF_NUM_REGS,
  parameter int IMM_W       = DEF_IMM_W,
  parameter int SHORT_IMM_W = DEF_SHORT_IMM_W,
  parameter int ZERO_REG    = 0
) (
  input logic          Clk,
  input logic          Reset_n,
  reg_file_sb_if.slave bus
);
  localparam int ADDR_W = $clog2(NUM_REGS);
  logic [DATA_W-1:0] r_mem [NUM_REGS];
  logic              w_wr_ok;
  logic [63:0]       w_long;
  logic [63:0]       w_short;
  // combinational reads with write bypass, hard-wired zero register and immediate select
  always_comb begin
    w_wr_ok = bus.RegWrite & ~((ZERO_REG != 0) && bus.Wr_Reg == '0);
    bus.Rd1_Data = ((ZERO_REG != 0) && bus.Rd1_Reg == '0) ? '0 :
                   (w_wr_ok && bus.Wr_Reg == bus.Rd1_Reg) ? bus.Wr_Data : r_mem[bus.Rd1_Reg];
    bus.Rd2_Data = ((ZERO_REG != 0) && bus.Rd2_Reg == '0) ? '0 :
                   (w_wr_ok && bus.Wr_Reg == bus.Rd2_Reg) ? bus.Wr_Data : r_mem[bus.Rd2_Reg];
    w_long  = sext(64'(bus.Immediate_Raw), IMM_W);
    w_short = sext(64'(bus.Immediate_Raw), SHORT_IMM_W);
    bus.Imm_Data = bus.ImmSel ? w_long[DATA_W-1:0] : w_short[DATA_W-1:0];
  end
  // storage: each register resets to its own index, then takes permitted writes
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_mem[i] <= DATA_W'(i);
    end else if (w_wr_ok) begin
      r_mem[bus.Wr_Reg] <= bus.Wr_Data;
    end
  end
  reg_scoreboard #(
    .NUM_REGS(NUM_REGS),
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG)
  ) u_sb (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .i_rd1_reg    (bus.Rd1_Reg),
    .i_rd1_en     (bus.Rd1_En),
    .i_rd2_reg    (bus.Rd2_Reg),
    .i_rd2_en     (bus.Rd2_En),
    .i_wr_reg     (bus.Wr_Reg),
    .i_wr_en      (bus.RegWrite),
    .i_issue_valid(bus.Issue_Valid),
    .i_issue_dest (bus.Issue_Dest),
    .o_issue_ready(bus.Issue_Ready),
    .o_issue_err  (bus.Issue_Err),
    .o_stall      (bus.Stall)
  );
endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised successor to the single-port accumulator-style register file.
- Provides two combinational read ports and one clocked write port, with same-cycle write-to-read bypass.
- A per-register pending-write scoreboard generates read stalls for a pipelined core.
- A shared immediate sign-extender is kept so the decode stage has one source for operands.

Parameters:
- DATA_W, 8, register and data width in bits.
- NUM_REGS, 8, number of registers (power of 2, at least 2).
- ADDR_W, $clog2(NUM_REGS), register index width (derived; do not override).
- IMM_W, 6, long immediate width (ImmSel=1); requires IMM_W <= DATA_W.
- SHORT_IMM_W, 3, short immediate width (ImmSel=0); requires SHORT_IMM_W <= IMM_W.
- ZERO_REG, 0, when 1 register 0 reads as 0, ignores writes and is never busy.

Ports:
- Clk  in  1  clock, rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Rd1_Reg  in  ADDR_W  read port 1 index.
- Rd1_En  in  1  port 1 operand is needed this cycle (qualifies stall).
- Rd1_Data  out  DATA_W  read port 1 data.
- Rd2_Reg  in  ADDR_W  read port 2 index.
- Rd2_En  in  1  port 2 operand is needed this cycle.
- Rd2_Data  out  DATA_W  read port 2 data.
- Wr_Reg  in  ADDR_W  write index.
- Wr_Data  in  DATA_W  write data.
- RegWrite  in  1  write enable.
- Issue_Valid  in  1  an instruction targeting Issue_Dest issues this cycle.
- Issue_Dest  in  ADDR_W  destination of the issuing instruction.
- Issue_Ready  out  1  Issue_Dest is not busy, so issue is legal.
- Issue_Err  out  1  registered 1-cycle pulse: issue attempted while not ready.
- Stall  out  1  an enabled read source is pending.
- Immediate_Raw  in  IMM_W  raw immediate field.
- ImmSel  in  1  1 selects the long immediate, 0 the short immediate.
- Imm_Data  out  DATA_W  sign-extended immediate.

Behaviour:
- Reset (Reset_n low, asynchronous):
  - RegMem[i] = i, truncated to DATA_W. Register 0 is 0 in all cases.
  - All busy bits are 0 and Issue_Err is 0.
  - After reset, Issue_Ready=1 and Stall=0; Rd*_Data show the index values.
- Reads are combinational with zero latency:
  - If RegWrite=1, Wr_Reg==RdN_Reg and the write is not suppressed, RdN_Data=Wr_Data (bypass).
  - Otherwise RdN_Data=RegMem[RdN_Reg].
  - With ZERO_REG=1 and RdN_Reg=0, RdN_Data=0.
- Write: on a rising Clk with RegWrite=1, RegMem[Wr_Reg] <= Wr_Data.
  - Suppressed when ZERO_REG=1 and Wr_Reg=0.
  - Both read ports may hit the same register and the same bypass.
- Scoreboard, vector busy[NUM_REGS]; updates at the rising edge:
  - Clear: RegWrite=1 clears busy[Wr_Reg].
  - Set: Issue_Valid=1 with Issue_Ready=1 sets busy[Issue_Dest].
  - Set and clear on the same register in the same cycle: set wins (new producer pending).
  - Issue_Ready = ~busy[Issue_Dest], except Issue_Ready=1 when a write to that register completes this cycle.
  - Issue_Valid=1 with Issue_Ready=0: busy is unchanged and Issue_Err=1 on the next cycle only. Upstream must hold the issue.
  - With ZERO_REG=1, register 0 is never set busy, and issuing to register 0 is always ready.
- Stall = (Rd1_En & pend1) | (Rd2_En & pend2).
  - pendN = busy[RdN_Reg] & ~(RegWrite & Wr_Reg==RdN_Reg).
  - The bypass therefore resolves the hazard in the same cycle.
  - Stall does not gate writes or issue inside the block.
- Immediate (combinational):
  - ImmSel=1: sign-extend Immediate_Raw[IMM_W-1:0] to DATA_W.
  - ImmSel=0: sign-extend Immediate_Raw[SHORT_IMM_W-1:0] to DATA_W.
- Reset mid-operation: pending busy bits and in-flight writes are discarded; state returns to the reset values immediately.
- Out-of-range indices cannot occur because NUM_REGS is a power of 2.

Decomposition:
- Shared package holds:
  - default DATA_W, NUM_REGS, IMM_W, SHORT_IMM_W;
  - localparam ADDR_W;
  - a sign-extend function parametrised by source width.
- Sub-module: reg_scoreboard, containing the busy vector, Issue_Ready, Issue_Err and the pendN/Stall logic. The storage, bypass and immediate logic stay in the top module.

Test Plan:
- Reset: pulse Reset_n low mid-cycle -> immediately Rd1_Reg=5 gives Rd1_Data=8'h05, Stall=0 and Issue_Ready=1; busy is all 0 after release.
- Write and bypass: RegWrite=1, Wr_Reg=3, Wr_Data=8'hA5, Rd1_Reg=Rd2_Reg=3 -> both reads give 8'hA5 in the same cycle and after the edge; Rd1_Reg=4 gives 8'h04.
- Scoreboard stall: issue to r2, then Rd1_En=1, Rd1_Reg=2 -> Stall=1; hold, then write r2=8'h3C -> Stall=0 that cycle with Rd1_Data=8'h3C, and busy[2]=0 after the edge.
- WAW and simultaneous events: issue r6 twice back to back -> second attempt gives Issue_Err=1 for one cycle and busy[6]=1. Write r6 while issuing r6 -> busy[6] stays 1 and Issue_Err=0.
- Immediate: Immediate_Raw=6'b100101 with ImmSel=1 -> 8'hE5; ImmSel=0 -> low bits 3'b101 give 8'hFD; Immediate_Raw=6'b011011 with ImmSel=0 -> 8'h03.
- ZERO_REG=1 variant: write r0=8'hFF then read r0 -> 8'h00; issue to r0 -> Issue_Ready=1, and Rd1_Reg=0 with Rd1_En=1 never stalls.
